fir_frame_writer: RTL and testbench
===================================

Name: fir_frame_writer

Overview:
Source-side producer for the FIR core's sample-write interface.
- Accepts 16-bit samples from an upstream valid/ready stream and buffers them in a small FIFO.
- Drives the core's data_in / in_write_ctrlX pair in frames of FRAME_LEN samples, throttled by the core's able2write_out.
- Flags each completed frame and counts frames.

Parameters:
DATA_W, 16, sample width
FRAME_LEN, 64, samples per frame (tap count of the core)
BUF_DEPTH, 4, internal FIFO depth (power of 2, >=2)
GAP_CYCLES, 2, idle cycles enforced between frames

Ports:
clk1  in  1  single clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
s_data  in  DATA_W  upstream sample
s_valid  in  1  upstream sample valid
s_ready  out  1  block can accept sample
able2write  in  1  from core able2write_out; 1 = core may accept writes
flush  in  1  pad current frame with zeros (only with macro)
data_out  out  DATA_W  to core data_in
write_ctrl  out  1  to core in_write_ctrlX; one sample per high cycle
frame_done  out  1  one-cycle pulse after last sample of a frame written
frame_count  out  16  frames completed, wraps 0xFFFF->0
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock (clk1); reset rst is asynchronous, active-high.
- Reset values: s_ready=0 during reset, then 1 after the first clock; data_out=0, write_ctrl=0, frame_done=0, frame_count=0, busy=0. FIFO emptied, sample counter=0, state=IDLE.
- Reset mid-frame: the partial frame is discarded, with no frame_done and no count change.
- Buffer:
  - s_ready = FIFO not full.
  - Push when s_valid & s_ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - No data loss or duplication.
- Write issue (all outputs registered):
  - At edge N, if state is BURST, able2write=1 and the FIFO is non-empty: pop, set data_out=head and write_ctrl=1 for cycle N+1.
  - Otherwise write_ctrl=0 and data_out holds its last value.
  - Because of the registered path, at most one write can follow the first low cycle of able2write. The core FIFO tolerates one write of overshoot.
- FSM:
  - IDLE: go to BURST when the FIFO is non-empty and able2write=1.
  - BURST: issue writes as above and increment the sample counter per write. When able2write=0 or the FIFO is empty, stay in BURST with no write (stall, not exit). On the FRAME_LEN-th write, go to GAP, reset the counter, pulse frame_done in the cycle after that write, and increment frame_count.
  - GAP: no writes for GAP_CYCLES cycles, then IDLE.
- frame_done coincides with frame_count already incremented.
- Counter width: clog2(FRAME_LEN)+1. The counter never exceeds FRAME_LEN.
- Upstream starvation mid-frame stalls indefinitely. There is no timeout.

Optional Feature:
FIR_WRITER_ZERO_PAD_EN
- Defined:
  - A flush pulse in BURST with counter>0 enters PAD.
  - PAD writes data_out=0 with write_ctrl=1 on each cycle with able2write=1, ignoring the FIFO, until FRAME_LEN is reached. Then frame_done and frame_count behave as normal, and the FSM goes to GAP.
  - Pushes into the FIFO continue during PAD.
  - flush in IDLE, GAP, or with counter=0 is ignored.
- Undefined: the flush input is ignored and the PAD state is not built.

Decomposition:
- Package fir_pkg: DATA_W / FRAME_LEN defaults, the state enum (IDLE, BURST, GAP, PAD), and the counter-width constant.
- One sub-module: sync_fifo_small, a single-clock FIFO of width DATA_W and depth BUF_DEPTH with full/empty flags and same-cycle push/pop.

Test Plan:
- Reset then continuous s_valid with samples 1..64 and able2write=1 -> 64 write_ctrl pulses with data_out=1..64 in order, then frame_done pulse, frame_count=1, then 2 idle cycles.
- Hold able2write=0 for cycles 10-19 of a frame -> at most 1 write after the drop and none afterwards. The frame resumes with no sample lost or duplicated, and still totals 64 writes.
- Upstream stalls (s_valid=0) after 5 samples -> FIFO fills and drains, and s_ready=0 while 4 entries are held with no draining. 64 writes, order preserved.
- Assert rst after 30 writes -> write_ctrl=0 immediately; frame_count stays 0. The next 64 samples produce frame_done and frame_count=1.
- Run 3 back-to-back frames -> frame_count=3 with exactly GAP_CYCLES gap between frames; force frame_count=0xFFFF -> wraps to 0.
- With FIR_WRITER_ZERO_PAD_EN: flush after 40 writes -> 24 writes with data_out=0, then frame_done. Without the macro, the same flush has no effect.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sample-writer slice: state encoding,
// parameter defaults and the per-frame sample counter width.
package fir_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int FRAME_LEN_DEF  = 64;
    localparam int BUF_DEPTH_DEF  = 4;
    localparam int GAP_CYCLES_DEF = 2;
    localparam int FRAME_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2,
        PAD   = 2'd3
    } state_t;

    // One extra bit so the counter can represent FRAME_LEN itself.
    function automatic int cntWidth(input int frameLen);
        return $clog2(frameLen) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_small.sv
// Small single-clock FIFO with full/empty flags; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo_small #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign head_o  = mem[rdPtr_q];

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem[wrPtr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fir_frame_writer.sv
// Buffers upstream samples and writes them to the FIR core in frames of FRAME_LEN.
// Optional zero-padding on flush is built when FIR_WRITER_ZERO_PAD_EN is defined.
module fir_frame_writer
    import fir_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FRAME_LEN  = FRAME_LEN_DEF,
    parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   able2write,
    input  logic                   flush,
    output logic [DATA_W-1:0]      data_out,
    output logic                   write_ctrl,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   busy
);

    localparam int CntW = cntWidth(FRAME_LEN);
    localparam int GapW = $clog2(GAP_CYCLES + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_LEN - 1);
    localparam logic [GapW-1:0] LastGap = GapW'(GAP_CYCLES - 1);

    state_t                 state_q, stateD;
    logic [CntW-1:0]        sampleCnt_q, sampleCntD;
    logic [GapW-1:0]        gapCnt_q, gapCntD;
    logic [DATA_W-1:0]      dataOut_q, dataD;
    logic                   write_q, writeD;
    logic                   donePend_q, donePendD;
    logic                   frameDone_q;
    logic [FRAME_CNT_W-1:0] frameCount_q;
    logic                   ready_q;

    logic                   fifoPush;
    logic                   fifoPop;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [DATA_W-1:0]      fifoHead;

    // ready_q keeps s_ready low while reset is held and for no longer.
    assign s_ready  = ready_q && !fifoFull;
    assign fifoPush = s_valid && s_ready;

    sync_fifo_small #(
        .WIDTH (DATA_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk_i   (clk1),
        .rst_i   (rst),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .wdata_i (s_data),
        .head_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

`ifndef FIR_WRITER_ZERO_PAD_EN
    logic unusedFlush;
    assign unusedFlush = flush;
`endif

    always_comb begin
        stateD     = state_q;
        sampleCntD = sampleCnt_q;
        gapCntD    = gapCnt_q;
        dataD      = dataOut_q;
        writeD     = 1'b0;
        donePendD  = 1'b0;
        fifoPop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty && able2write) begin
                    stateD = BURST;
                end
            end
            BURST: begin
`ifdef FIR_WRITER_ZERO_PAD_EN
                if (flush && (sampleCnt_q != '0)) begin
                    stateD = PAD;
                end else
`endif
                if (able2write && !fifoEmpty) begin
                    fifoPop = 1'b1;
                    writeD  = 1'b1;
                    dataD   = fifoHead;
                end
            end
            GAP: begin
                if (gapCnt_q == LastGap) begin
                    stateD = IDLE;
                end else begin
                    gapCntD = gapCnt_q + GapW'(1);
                end
            end
`ifdef FIR_WRITER_ZERO_PAD_EN
            PAD: begin
                if (able2write) begin
                    writeD = 1'b1;
                    dataD  = '0;
                end
            end
`endif
            default: stateD = IDLE;
        endcase
        // Frame accounting is shared by FIFO writes and zero-pad writes.
        if (writeD) begin
            if (sampleCnt_q == LastIdx) begin
                sampleCntD = '0;
                gapCntD    = '0;
                stateD     = GAP;
                donePendD  = 1'b1;
            end else begin
                sampleCntD = sampleCnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sampleCnt_q  <= '0;
            gapCnt_q     <= '0;
            dataOut_q    <= '0;
            write_q      <= 1'b0;
            donePend_q   <= 1'b0;
            frameDone_q  <= 1'b0;
            frameCount_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q     <= stateD;
            sampleCnt_q <= sampleCntD;
            gapCnt_q    <= gapCntD;
            dataOut_q   <= dataD;
            write_q     <= writeD;
            donePend_q  <= donePendD;
            frameDone_q <= donePend_q;
            ready_q     <= 1'b1;
            if (donePend_q) begin
                frameCount_q <= frameCount_q + FRAME_CNT_W'(1);
            end
        end
    end

    assign data_out    = dataOut_q;
    assign write_ctrl  = write_q;
    assign frame_done  = frameDone_q;
    assign frame_count = frameCount_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fir_frame_writer.sv
// Directed self-checking bench for fir_frame_writer; expectations follow the
// FIR_WRITER_ZERO_PAD_EN setting of the build.
module tb_fir_frame_writer;
    import fir_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int FL = FRAME_LEN_DEF;
    localparam int BD = BUF_DEPTH_DEF;
    localparam int GC = GAP_CYCLES_DEF;

    logic                   clk1 = 1'b0;
    logic                   rst = 1'b0;
    logic [DW-1:0]          s_data = '0;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic                   able2write = 1'b0;
    logic                   flush = 1'b0;
    logic [DW-1:0]          data_out;
    logic                   write_ctrl;
    logic                   frame_done;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic                   busy;

    int nCompared = 0;
    int nMismatched = 0;
    int cyc = 0;
    bit srcEn = 1'b0;

    logic [DW-1:0] srcQ[$];
    logic [DW-1:0] wrData[$];
    int            wrCyc[$];
    int            doneCyc[$];

    fir_frame_writer #(
        .DATA_W     (DW),
        .FRAME_LEN  (FL),
        .BUF_DEPTH  (BD),
        .GAP_CYCLES (GC)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .able2write  (able2write),
        .flush       (flush),
        .data_out    (data_out),
        .write_ctrl  (write_ctrl),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    // Offer the next sample only when it will certainly be taken at the coming edge.
    always @(negedge clk1) begin
        if (srcEn && (srcQ.size() > 0) && s_ready && !rst) begin
            s_valid = 1'b1;
            s_data  = srcQ.pop_front();
        end else begin
            s_valid = 1'b0;
        end
    end

    always @(negedge clk1) begin
        if (write_ctrl) begin
            wrData.push_back(data_out);
            wrCyc.push_back(cyc);
        end
        if (frame_done) begin
            doneCyc.push_back(cyc);
        end
    end

    task automatic step();
        @(negedge clk1);
        #1;
    endtask

    task automatic applyStimulus(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            srcQ.push_back(DW'(first + i));
        end
    endtask

    task automatic resetDut();
        srcEn = 1'b0;
        srcQ.delete();
        able2write = 1'b0;
        flush = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        wrData.delete();
        wrCyc.delete();
        doneCyc.delete();
    endtask

    task automatic waitWrites(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (wrData.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitDone(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (doneCyc.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        srcEn = 1'b0;
        able2write = 1'b0;
        #2 rst = 1'b1;
        repeat (2) step();
        nCompared++;
        if (s_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_s_ready: got %0b want 0", s_ready); end
        nCompared++;
        if (data_out !== '0) begin nMismatched++; $display("[TB] FAIL reset_data_out: got %0h want 0", data_out); end
        nCompared++;
        if (write_ctrl !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_write_ctrl: got %0b want 0", write_ctrl); end
        nCompared++;
        if (frame_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_frame_done: got %0b want 0", frame_done); end
        nCompared++;
        if (frame_count !== '0) begin nMismatched++; $display("[TB] FAIL reset_frame_count: got %0d want 0", frame_count); end
        nCompared++;
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        rst = 1'b0;
        #1;
        nCompared++;
        if (s_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL ready_before_clock: got %0b want 0", s_ready); end
        step();
        nCompared++;
        if (s_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL ready_after_clock: got %0b want 1", s_ready); end
    endtask

    task automatic test_basic_frame();
        bit ok;
        int errs;
        resetDut();
        applyStimulus(1, FL);
        able2write = 1'b1;
        srcEn = 1'b1;
        waitDone(1, 400, ok);
        nCompared++;
        if (!ok) begin nMismatched++; $display("[TB] FAIL basic_done_timeout: got no frame_done want one"); end
        nCompared++;
        if (wrData.size() != FL) begin nMismatched++; $display("[TB] FAIL basic_write_count: got %0d want %0d", wrData.size(), FL); end
        errs = 0;
        for (int i = 0; i < wrData.size(); i++) if (wrData[i] !== DW'(i + 1)) errs++;
        nCompared++;
        if (errs != 0) begin nMismatched++; $display("[TB] FAIL basic_order: got %0d bad samples want 0", errs); end
        nCompared++;
        if (frame_count !== 16'd1) begin nMismatched++; $display("[TB] FAIL basic_frame_count: got %0d want 1", frame_count); end
        nCompared++;
        if (ok && wrCyc.size() == FL && doneCyc[0] != wrCyc[FL-1] + 1) begin
            nMismatched++; $display("[TB] FAIL basic_done_timing: got cycle %0d want %0d", doneCyc[0], wrCyc[FL-1] + 1);
        end
        nCompared++;
        if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_busy_in_gap: got %0b want 1", busy); end
        step();
        nCompared++;
        if (frame_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_done_pulse: got %0b want 0", frame_done); end
        nCompared++;
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_idle_after_gap: got %0b want 0", busy); end
        repeat (GC + 2) step();
        nCompared++;
        if (wrData.size() != FL) begin nMismatched++; $display("[TB] FAIL basic_no_extra_writes: got %0d want %0d", wrData.size(), FL); end
    endtask

    task automatic test_able2write_drop();
        bit ok;
        int errs;
        int base;
        int afterFirst;
        resetDut();
        applyStimulus(201, FL);
        able2write = 1'b1;
        srcEn = 1'b1;
        waitWrites(10, 100, ok);
        able2write = 1'b0;
        base = wrData.size();
        step();
        afterFirst = wrData.size();
        nCompared++;
        if (afterFirst - base > 1) begin nMismatched++; $display("[TB] FAIL drop_overshoot: got %0d writes want <=1", afterFirst - base); end
        repeat (9) step();
        nCompared++;
        if (wrData.size() != afterFirst) begin nMismatched++; $display("[TB] FAIL drop_no_writes: got %0d writes want 0", wrData.size() - afterFirst); end
        nCompared++;
        if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL drop_stays_burst: got busy %0b want 1", busy); end
        able2write = 1'b1;
        waitDone(1, 400, ok);
        nCompared++;
        if (!ok || wrData.size() != FL) begin nMismatched++; $display("[TB] FAIL drop_total: got %0d writes want %0d", wrData.size(), FL); end
        errs = 0;
        for (int i = 0; i < wrData.size(); i++) if (wrData[i] !== DW'(201 + i)) errs++;
        nCompared++;
        if (errs != 0) begin nMismatched++; $display("[TB] FAIL drop_order: got %0d bad samples want 0", errs); end
    endtask

    task automatic test_upstream_stall();
        bit ok;
        int errs;
        int held;
        resetDut();
        applyStimulus(301, FL);
        able2write = 1'b1;
        srcEn = 1'b1;
        waitWrites(5, 100, ok);
        srcEn = 1'b0;
        repeat (10) step();
        nCompared++;
        if (busy !== 1'b1 || doneCyc.size() != 0) begin
            nMismatched++; $display("[TB] FAIL stall_keeps_frame: got busy %0b dones %0d want 1 0", busy, doneCyc.size());
        end
        able2write = 1'b0;
        srcEn = 1'b1;
        repeat (8) step();
        nCompared++;
        if (s_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_full_ready: got %0b want 0", s_ready); end
        held = wrData.size();
        repeat (3) step();
        nCompared++;
        if (wrData.size() != held) begin nMismatched++; $display("[TB] FAIL stall_no_drain: got %0d writes want 0", wrData.size() - held); end
        able2write = 1'b1;
        waitDone(1, 400, ok);
        nCompared++;
        if (!ok || wrData.size() != FL) begin nMismatched++; $display("[TB] FAIL stall_total: got %0d writes want %0d", wrData.size(), FL); end
        errs = 0;
        for (int i = 0; i < wrData.size(); i++) if (wrData[i] !== DW'(301 + i)) errs++;
        nCompared++;
        if (errs != 0) begin nMismatched++; $display("[TB] FAIL stall_order: got %0d bad samples want 0", errs); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int errs;
        resetDut();
        applyStimulus(401, FL);
        able2write = 1'b1;
        srcEn = 1'b1;
        waitWrites(30, 100, ok);
        rst = 1'b1;
        srcEn = 1'b0;
        srcQ.delete();
        #1;
        nCompared++;
        if (write_ctrl !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_write_ctrl: got %0b want 0", write_ctrl); end
        repeat (2) step();
        nCompared++;
        if (frame_count !== '0 || doneCyc.size() != 0) begin
            nMismatched++; $display("[TB] FAIL midrst_count: got count %0d dones %0d want 0 0", frame_count, doneCyc.size());
        end
        rst = 1'b0;
        step();
        wrData.delete();
        wrCyc.delete();
        applyStimulus(601, FL);
        srcEn = 1'b1;
        waitDone(1, 400, ok);
        nCompared++;
        if (!ok || frame_count !== 16'd1) begin nMismatched++; $display("[TB] FAIL midrst_next_frame: got count %0d want 1", frame_count); end
        errs = 0;
        for (int i = 0; i < wrData.size(); i++) if (wrData[i] !== DW'(601 + i)) errs++;
        nCompared++;
        if (errs != 0 || wrData.size() != FL) begin
            nMismatched++; $display("[TB] FAIL midrst_order: got %0d writes %0d bad want %0d 0", wrData.size(), errs, FL);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int errs;
        resetDut();
        applyStimulus(1000, 3 * FL);
        able2write = 1'b1;
        srcEn = 1'b1;
        waitDone(3, 900, ok);
        nCompared++;
        if (!ok || frame_count !== 16'd3) begin nMismatched++; $display("[TB] FAIL b2b_frame_count: got %0d want 3", frame_count); end
        errs = 0;
        for (int i = 0; i < wrData.size(); i++) if (wrData[i] !== DW'(1000 + i)) errs++;
        nCompared++;
        if (errs != 0 || wrData.size() != 3 * FL) begin
            nMismatched++; $display("[TB] FAIL b2b_order: got %0d writes %0d bad want %0d 0", wrData.size(), errs, 3 * FL);
        end
        // Between frames: GC cycles of GAP plus the single IDLE re-arm cycle.
        if (wrCyc.size() == 3 * FL) begin
            nCompared++;
            if (wrCyc[FL] - wrCyc[FL-1] != GC + 2) begin
                nMismatched++; $display("[TB] FAIL b2b_gap1: got %0d want %0d", wrCyc[FL] - wrCyc[FL-1], GC + 2);
            end
            nCompared++;
            if (wrCyc[2*FL] - wrCyc[2*FL-1] != GC + 2) begin
                nMismatched++; $display("[TB] FAIL b2b_gap2: got %0d want %0d", wrCyc[2*FL] - wrCyc[2*FL-1], GC + 2);
            end
            nCompared++;
            if (wrCyc[2*FL-1] - wrCyc[FL] != FL - 1) begin
                nMismatched++; $display("[TB] FAIL b2b_frame2_span: got %0d want %0d", wrCyc[2*FL-1] - wrCyc[FL], FL - 1);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        resetDut();
        force dut.frameCount_q = 16'hFFFF;
        step();
        release dut.frameCount_q;
        applyStimulus(700, FL);
        able2write = 1'b1;
        srcEn = 1'b1;
        waitDone(1, 400, ok);
        nCompared++;
        if (!ok || frame_count !== 16'h0000) begin nMismatched++; $display("[TB] FAIL wrap_count: got %0h want 0", frame_count); end
        repeat (GC + 2) step();
        nCompared++;
        if (frame_count !== 16'h0000) begin nMismatched++; $display("[TB] FAIL wrap_hold: got %0h want 0", frame_count); end
    endtask

    task automatic test_flush();
        bit ok;
        int errs;
        logic [DW-1:0] expv;
        logic [DW-1:0] nextExp;
        resetDut();
        applyStimulus(501, FL + 4);
        able2write = 1'b1;
        srcEn = 1'b1;
        waitWrites(40, 100, ok);
        flush = 1'b1;
        step();
        flush = 1'b0;
        waitDone(1, 400, ok);
        nCompared++;
        if (!ok || frame_count !== 16'd1) begin nMismatched++; $display("[TB] FAIL flush_done: got count %0d want 1", frame_count); end
        errs = 0;
        for (int i = 0; i < wrData.size(); i++) begin
`ifdef FIR_WRITER_ZERO_PAD_EN
            expv = (i < 40) ? DW'(501 + i) : '0;
`else
            expv = DW'(501 + i);
`endif
            if (wrData[i] !== expv) errs++;
        end
        nCompared++;
        if (errs != 0 || wrData.size() != FL) begin
            nMismatched++; $display("[TB] FAIL flush_data: got %0d writes %0d bad want %0d 0", wrData.size(), errs, FL);
        end
`ifdef FIR_WRITER_ZERO_PAD_EN
        nextExp = DW'(541);
`else
        nextExp = DW'(501 + FL);
`endif
        waitWrites(FL + 1, 50, ok);
        nCompared++;
        if (!ok || wrData[FL] !== nextExp) begin
            nMismatched++; $display("[TB] FAIL flush_next_sample: got %0d want %0d", ok ? int'(wrData[FL]) : -1, nextExp);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_able2write_drop();
        test_upstream_stall();
        test_reset_mid_frame();
        test_back_to_back();
        test_wrap();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
